seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Time-multiplexed driver for the 8-digit, common-anode seven-segment display. It sits directly downstream of the ALU and takes the ALU's 32-bit `results` word. It shows that word as 8 hexadecimal digits, one digit active at a time. Updates are double-buffered, so a new word appears only at a frame boundary and no frame ever shows a mix of old and new digits.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clock cycles each digit stays lit (1 ms at 100 MHz). Legal range ≥ 1.
- `BLANK_LZ`, default 0: when 1, leading-zero digits are blanked.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `data`  input  32  word to display (ALU `results`).
- `load`  input  1  one-cycle strobe; captures `data` on the same edge.
- `an`  output  8  digit enables, active-low; `an[i]` selects digit i, and digit 0 is the rightmost.
- `seg`  output  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  output  1  decimal point, active-low; tied to 1 (off).

## Operation
- State registers:
  - `cnt`: width clog2(SCAN_DIV), minimum 1 bit.
  - `idx[2:0]`: active digit.
  - `disp[31:0]`: shown word.
  - `pend[31:0]`: buffered word.
  - `pflag`: buffered-word-waiting flag.
- Outputs are combinational decodes of the registered state only. `data` and `load` never reach the outputs directly.
- Scan counter:
  - `tick` = (`cnt` == SCAN_DIV−1).
  - On `tick`: `cnt`←0 and `idx`←`idx`+1, wrapping from 7 to 0.
  - Otherwise `cnt`←`cnt`+1.
- Frame end: `fend` = `tick` && `idx`==7.
- Load buffering:
  - `load` without `fend`: `pend`←`data`, `pflag`←1. A later `load` before the frame end overwrites `pend`, so the last one wins.
  - `fend` without `load`: if `pflag`, then `disp`←`pend` and `pflag`←0.
  - `load` and `fend` on the same cycle: `disp`←`data` directly and `pflag`←0. Any older `pend` is discarded.
- Digit decode:
  - Nibble n = `disp[4*idx+3 : 4*idx]`.
  - `an` = all ones except bit `idx` = 0.
  - `seg` hex map:
    - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
    - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Blanking (BLANK_LZ=1):
  - Digit `idx` is blanked when `idx` > 0 and every nibble from `idx` up to 7 is zero.
  - A blanked digit drives `an`=FF and `seg`=7F.
  - Digit 0 is never blanked, so `disp`=0 shows a single "0".
- Reset (`rst`=1 at an edge):
  - `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pflag`=0.
  - Resulting outputs: `an`=FE, `seg`=40, `dp`=1.
  - Reset takes priority over `load` in the same cycle, and a buffered word is dropped.

## Timing
- Each digit is active for exactly SCAN_DIV cycles. A frame is 8·SCAN_DIV cycles. After reset, digit order is 0,1,…,7,0,…
- `an` changes only on the edge where `tick` is true.
- Load-to-display latency:
  - From 1 cycle, when `load` coincides with `fend`,
  - up to 8·SCAN_DIV cycles, when `load` arrives one cycle after `fend`.
  - The new word first appears together with `an`=FE.
- `disp` never changes except at `fend` or reset, so every frame is coherent.
- SCAN_DIV=1: `tick` is true every cycle, `idx` advances every cycle, and `fend` occurs every 8th cycle.

## Test plan
Run with SCAN_DIV=4 unless stated otherwise.
- Reset then idle for 32 cycles:
  - `an` steps FE, FD, FB, F7, EF, DF, BF, 7F, each held for 4 cycles.
  - `seg`=40 throughout; `dp`=1.
- `load` with `data`=0x1234ABCD in mid-frame:
  - The current frame still shows zeros.
  - From the next `an`=FE onward, digits 0..7 show D,C,B,A,4,3,2,1, i.e. `seg` = 21, 46, 03, 08, 19, 30, 24, 79.
- `load` with 0x11111111, then 3 cycles later `load` with 0x22222222, both inside one frame:
  - The next frame shows all digits `seg`=24.
  - 0x11111111 is never displayed.
- `load` with 0xFFFFFFFF on the exact `fend` cycle:
  - The very next cycle shows `an`=FE and `seg`=0E.
- `load` with 0x000000A5 and BLANK_LZ=1:
  - Digit 0 shows `seg`=12 and digit 1 shows `seg`=08.
  - Digits 2–7 drive `an`=FF and `seg`=7F.
  - Then `load` with 0 gives only digit 0 lit, showing `seg`=40.
- `load` with 0x55555555, then assert `rst` for 1 cycle before `fend`:
  - On the next edge, `an`=FE and `seg`=40.
  - 0x55555555 never appears; scanning restarts at digit 0 with the full 4-cycle dwell.

Source files
------------

// File: rtl/seg_scan_display.sv
`timescale 1ns/1ps
// seg_scan_display: 8-digit common-anode hex display scanner.
// Shows a 32-bit word one digit at a time; new words are double-buffered
// and only take effect at the end of a full scan frame.
module seg_scan_display #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned BLANK_LZ = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        load,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   disp;
  logic [31:0]   pend;
  logic          pflag;

  logic          tick;
  logic          fend;
  logic [3:0]    nib;
  logic          blank;

  assign tick = (cnt == CNT_LAST);
  assign fend = tick && (idx == 3'd7);
  assign dp   = 1'b1;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan counter, digit index and double-buffered display word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= 3'd0;
      disp  <= 32'd0;
      pend  <= 32'd0;
      pflag <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      // A load landing exactly on the frame end bypasses the buffer, so the
      // newest word wins and any older pending word is discarded.
      if (load && fend) begin
        disp  <= data;
        pflag <= 1'b0;
      end else if (load) begin
        pend  <= data;
        pflag <= 1'b1;
      end else if (fend && pflag) begin
        disp  <= pend;
        pflag <= 1'b0;
      end
    end
  end

  // Digit decode from registered state only; leading zeros optionally blanked.
  always_comb begin
    nib   = disp[{idx, 2'b00} +: 4];
    blank = 1'b0;
    if ((BLANK_LZ != 0) && (idx != 3'd0)) begin
      blank = ((disp >> {idx, 2'b00}) == 32'd0);
    end
    an  = 8'hFF;
    seg = 7'h7F;
    if (!blank) begin
      an  = ~(8'h01 << idx);
      seg = hex2seg(nib);
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
`timescale 1ns/1ps
// Scoreboard bench for seg_scan_display. Stimulus pushes the expected
// display outputs for every cycle; a negedge monitor pops and compares.
// Instance a: SCAN_DIV=4, no blanking. Instance b: SCAN_DIV=4, blanking.
// Instance c: SCAN_DIV=1, digit-enable sequence only.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = 32'd0;
  logic        load = 1'b0;

  logic [7:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;

  typedef struct packed {
    logic [7:0] an_a;
    logic [6:0] seg_a;
    logic [7:0] an_b;
    logic [6:0] seg_b;
    logic [7:0] an_c;
  } exp_t;

  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;
  int s = 0;
  logic [31:0] shown = 32'd0;

  always #5 clk = ~clk;

  seg_scan_display #(.SCAN_DIV(4), .BLANK_LZ(0)) u_a (
    .clk(clk), .rst(rst), .data(data), .load(load),
    .an(an_a), .seg(seg_a), .dp(dp_a));

  seg_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1)) u_b (
    .clk(clk), .rst(rst), .data(data), .load(load),
    .an(an_b), .seg(seg_b), .dp(dp_b));

  seg_scan_display #(.SCAN_DIV(1), .BLANK_LZ(0)) u_c (
    .clk(clk), .rst(rst), .data(data), .load(load),
    .an(an_c), .seg(seg_c), .dp(dp_c));

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[h];
  endfunction

  task automatic push_exp();
    exp_t e;
    int d;
    int d1;
    logic [31:0] w;
    d  = (s / 4) % 8;
    d1 = s % 8;
    w  = shown;
    e.an_a  = ~(8'h01 << d);
    e.seg_a = seg_of(w[4*d +: 4]);
    if (d != 0 && (w >> (4*d)) == 32'd0) begin
      e.an_b  = 8'hFF;
      e.seg_b = 7'h7F;
    end else begin
      e.an_b  = e.an_a;
      e.seg_b = e.seg_a;
    end
    e.an_c = ~(8'h01 << d1);
    q.push_back(e);
  endtask

  // One clock: apply inputs, take the edge, record what must be shown next.
  task automatic cyc(input logic r, input logic ld, input logic [31:0] d,
                     input logic chg, input logic [31:0] nw);
    rst  = r;
    load = ld;
    data = d;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    load = 1'b0;
    if (r) begin
      s     = 0;
      shown = 32'd0;
    end else begin
      s = s + 1;
    end
    if (chg) shown = nw;
    push_exp();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic idle_to_last();
    while (s % 32 != 31) idle();
  endtask

  task automatic idle_to(input int tgt);
    while (s < tgt) idle();
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at s=%0d: got %h, want %h", nm, s, act, exp);
    end
  endtask

  // Monitor: every cycle with an outstanding expectation is compared.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an_a",  an_a,  e.an_a);
      chk("seg_a", {1'b0, seg_a}, {1'b0, e.seg_a});
      chk("dp_a",  {7'd0, dp_a}, 8'd1);
      chk("an_b",  an_b,  e.an_b);
      chk("seg_b", {1'b0, seg_b}, {1'b0, e.seg_b});
      chk("an_c",  an_c,  e.an_c);
      chk("dp_c",  {7'd0, dp_c}, 8'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then a full idle frame of zeros.
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    idle_to_last();
    idle();

    // Mid-frame load appears only from the next frame start.
    idle_to(41);
    cyc(1'b0, 1'b1, 32'h1234ABCD, 1'b0, 32'd0);
    idle_to_last();
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h1234ABCD);
    idle_to_last();

    // Two loads in one frame: last wins, first never shown.
    idle();
    cyc(1'b0, 1'b1, 32'h11111111, 1'b0, 32'd0);
    idle();
    idle();
    cyc(1'b0, 1'b1, 32'h22222222, 1'b0, 32'd0);
    idle_to_last();
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h22222222);
    idle_to_last();

    // Load exactly on the frame-end cycle shows on the very next cycle.
    cyc(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF);
    idle_to_last();

    // Leading-zero blanking on instance b.
    idle();
    cyc(1'b0, 1'b1, 32'h000000A5, 1'b0, 32'd0);
    idle_to_last();
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h000000A5);
    idle_to_last();
    idle();
    cyc(1'b0, 1'b1, 32'h00000000, 1'b0, 32'd0);
    idle_to_last();
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h00000000);
    idle_to_last();

    // Buffered word dropped by a reset just before frame end; reset beats load.
    idle();
    cyc(1'b0, 1'b1, 32'h55555555, 1'b0, 32'd0);
    idle_to(350);
    cyc(1'b1, 1'b1, 32'h77777777, 1'b0, 32'd0);
    idle_to_last();
    idle_to(40);

    @(negedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
